// File: rtl/aes_out_pkg.sv
// Shared widths, word-index type and helpers for the AES output serializer.
package aes_out_pkg;

    localparam int unsigned BLOCK_W         = 128;
    localparam int unsigned WORD_W          = 32;
    localparam int unsigned WORDS_PER_BLOCK = 4;

    typedef logic [1:0] word_idx_t;

    localparam word_idx_t FIRST_WORD = 2'd0;
    localparam word_idx_t LAST_WORD  = 2'd3;

    // Word 0 is the most significant 32 bits of the block.
    function automatic logic [WORD_W-1:0] block_word(input logic [BLOCK_W-1:0] blk,
                                                     input word_idx_t idx);
        logic [WORD_W-1:0] w;
        w = '0;
        unique case (idx)
            2'd0: w = blk[127:96];
            2'd1: w = blk[95:64];
            2'd2: w = blk[63:32];
            2'd3: w = blk[31:0];
            default: w = '0;
        endcase
        return w;
    endfunction

    function automatic logic even_parity(input logic [WORD_W-1:0] w);
        return ^w;
    endfunction

endpackage

// File: rtl/aes_out_fifo.sv
// DEPTH x 128-bit block FIFO; a push is accepted when full if a pop occurs on the same edge.
module aes_out_fifo
    import aes_out_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [BLOCK_W-1:0]       push_data,
    input  logic                     pop,
    output logic [BLOCK_W-1:0]       head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [BLOCK_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]   level_q, level_d;
    logic               do_push, do_pop;

    assign full    = (level_q == LVL_W'(DEPTH));
    assign empty   = (level_q == '0);
    assign level   = level_q;
    assign head    = mem[rd_ptr_q];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // DEPTH is a power of two, so pointers wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        unique case ({do_push, do_pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage is deliberately not reset; the pointers alone define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/aes_out_serializer.sv
// Buffers 128-bit AES output blocks and streams them as 32-bit words, MSB word first.
// Optional ser_parity output is built when AES_OUT_PARITY_EN is defined.
module aes_out_serializer
    import aes_out_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                     AES_clk,
    input  logic                     AES_rst,
    input  logic                     AES_data_out_valid,
    input  logic [BLOCK_W-1:0]       AES_data_out,
    output logic [WORD_W-1:0]        ser_data,
    output logic                     ser_valid,
    input  logic                     ser_ready,
    output logic                     ser_last,
    output logic [$clog2(DEPTH):0]   ser_level,
    output logic                     ser_ovf
`ifdef AES_OUT_PARITY_EN
    ,
    output logic                     ser_parity
`endif
);

    logic [BLOCK_W-1:0] head;
    logic               fifo_full;
    logic               fifo_empty;
    word_idx_t          word_q, word_d;
    logic               ovf_q, ovf_d;
    logic               xfer;
    logic               pop;

    aes_out_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (AES_clk),
        .rst       (AES_rst),
        .push      (AES_data_out_valid),
        .push_data (AES_data_out),
        .pop       (pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (ser_level)
    );

    assign ser_valid = !fifo_empty;
    assign xfer      = ser_valid && ser_ready;
    assign pop       = xfer && (word_q == LAST_WORD);

    always_comb begin
        word_d = word_q;
        ovf_d  = ovf_q;
        if (xfer) begin
            word_d = word_q + 2'd1;
        end
        // A block arriving into a full FIFO is lost unless the head leaves on the same edge.
        if (AES_data_out_valid && fifo_full && !pop) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge AES_clk or posedge AES_rst) begin
        if (AES_rst) begin
            word_q <= FIRST_WORD;
            ovf_q  <= 1'b0;
        end else begin
            word_q <= word_d;
            ovf_q  <= ovf_d;
        end
    end

    assign ser_data = ser_valid ? block_word(head, word_q) : '0;
    assign ser_last = ser_valid && (word_q == LAST_WORD);
    assign ser_ovf  = ovf_q;

`ifdef AES_OUT_PARITY_EN
    // Derived only from registered state, so it changes exactly when ser_data does.
    assign ser_parity = even_parity(ser_data);
`endif

endmodule

// File: tb/tb_aes_out_serializer.sv
// Directed self-checking bench for aes_out_serializer (DEPTH = 2).
module tb_aes_out_serializer;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic [127:0] in_data;
    logic [31:0]  ser_data;
    logic         ser_valid;
    logic         ser_ready;
    logic         ser_last;
    logic [1:0]   ser_level;
    logic         ser_ovf;
`ifdef AES_OUT_PARITY_EN
    logic         ser_parity;
`endif

    int checks = 0;
    int errors = 0;

    localparam logic [127:0] B1 = 128'h3925841d_02dc09fb_dc118597_196a0b32;
    localparam logic [127:0] B2 = 128'h00112233_44556677_8899aabb_ccddeeff;
    localparam logic [127:0] B3 = 128'hcafef00d_deadbeef_01234567_89abcdef;

    logic [31:0] b1w [4] = '{32'h3925841d, 32'h02dc09fb, 32'hdc118597, 32'h196a0b32};
    logic [31:0] b2w [4] = '{32'h00112233, 32'h44556677, 32'h8899aabb, 32'hccddeeff};
    logic [31:0] b3w [4] = '{32'hcafef00d, 32'hdeadbeef, 32'h01234567, 32'h89abcdef};

    aes_out_serializer #(
        .DEPTH (2)
    ) dut (
        .AES_clk            (clk),
        .AES_rst            (rst),
        .AES_data_out_valid (in_valid),
        .AES_data_out       (in_data),
        .ser_data           (ser_data),
        .ser_valid          (ser_valid),
        .ser_ready          (ser_ready),
        .ser_last           (ser_last),
        .ser_level          (ser_level),
        .ser_ovf            (ser_ovf)
`ifdef AES_OUT_PARITY_EN
        ,
        .ser_parity         (ser_parity)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        ser_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        // Reset state
        do_reset();
        check_eq("rst_valid", 32'(ser_valid), 32'd0);
        check_eq("rst_data", ser_data, 32'd0);
        check_eq("rst_last", 32'(ser_last), 32'd0);
        check_eq("rst_level", 32'(ser_level), 32'd0);
        check_eq("rst_ovf", 32'(ser_ovf), 32'd0);
`ifdef AES_OUT_PARITY_EN
        check_eq("rst_parity", 32'(ser_parity), 32'd0);
`endif

        // Single block, ready held high: 4 consecutive words after capture
        in_valid = 1'b1; in_data = B1; ser_ready = 1'b1;
        tick();
        in_valid = 1'b0;
`ifdef AES_OUT_PARITY_EN
        check_eq("parity_w0", 32'(ser_parity), 32'd1);
`endif
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("single_data%0d", i), ser_data, b1w[i]);
            check_eq($sformatf("single_last%0d", i), 32'(ser_last), (i == 3) ? 32'd1 : 32'd0);
            check_eq($sformatf("single_valid%0d", i), 32'(ser_valid), 32'd1);
            tick();
        end
        check_eq("single_empty", 32'(ser_valid), 32'd0);

        // Two blocks one cycle apart: 8 words, no bubble
        do_reset();
        ser_ready = 1'b1;
        in_valid = 1'b1; in_data = B1;
        tick();
        in_data = B2;
        for (int i = 0; i < 8; i++) begin
            logic [31:0] lvl_exp [8];
            lvl_exp = '{32'd1, 32'd2, 32'd2, 32'd2, 32'd1, 32'd1, 32'd1, 32'd1};
            check_eq($sformatf("two_data%0d", i), ser_data, (i < 4) ? b1w[i] : b2w[i-4]);
            check_eq($sformatf("two_level%0d", i), 32'(ser_level), lvl_exp[i]);
            tick();
            in_valid = 1'b0;
        end
        check_eq("two_level_end", 32'(ser_level), 32'd0);

        // Backpressure at word 1 for 5 cycles
        do_reset();
        ser_ready = 1'b1;
        in_valid = 1'b1; in_data = B1;
        tick();
        in_valid = 1'b0;
        tick();
        ser_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check_eq($sformatf("hold_data%0d", i), ser_data, b1w[1]);
            check_eq($sformatf("hold_last%0d", i), 32'(ser_last), 32'd0);
            tick();
        end
        ser_ready = 1'b1;
        tick();
        check_eq("resume_w2", ser_data, b1w[2]);
        tick();
        check_eq("resume_w3", ser_data, b1w[3]);
        check_eq("resume_last", 32'(ser_last), 32'd1);

        // Overflow: DEPTH+1 captures with ready low
        do_reset();
        in_valid = 1'b1; in_data = B1;
        tick();
        in_data = B2;
        tick();
        check_eq("ovf_before", 32'(ser_ovf), 32'd0);
        in_data = B3;
        tick();
        in_valid = 1'b0;
        check_eq("ovf_set", 32'(ser_ovf), 32'd1);
        check_eq("ovf_level", 32'(ser_level), 32'd2);
        ser_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check_eq($sformatf("ovf_data%0d", i), ser_data, (i < 4) ? b1w[i] : b2w[i-4]);
            tick();
        end
        check_eq("ovf_drained", 32'(ser_valid), 32'd0);
        check_eq("ovf_sticky", 32'(ser_ovf), 32'd1);

        // Push into a full FIFO on the same edge as a pop: accepted, no overflow
        do_reset();
        in_valid = 1'b1; in_data = B1;
        tick();
        in_data = B2;
        tick();
        in_valid = 1'b0;
        ser_ready = 1'b1;
        tick();
        tick();
        tick();
        check_eq("pp_w3", ser_data, b1w[3]);
        in_valid = 1'b1; in_data = B3;
        tick();
        in_valid = 1'b0;
        check_eq("pp_level", 32'(ser_level), 32'd2);
        check_eq("pp_ovf", 32'(ser_ovf), 32'd0);
        for (int i = 0; i < 8; i++) begin
            check_eq($sformatf("pp_data%0d", i), ser_data, (i < 4) ? b2w[i] : b3w[i-4]);
            tick();
        end
        check_eq("pp_drained", 32'(ser_level), 32'd0);

        // Asynchronous reset after word 2 has been sent
        do_reset();
        ser_ready = 1'b1;
        in_valid = 1'b1; in_data = B1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        check_eq("mid_w3", ser_data, b1w[3]);
        rst = 1'b1;
        #1;
        check_eq("mid_rst_valid", 32'(ser_valid), 32'd0);
        check_eq("mid_rst_data", ser_data, 32'd0);
        check_eq("mid_rst_last", 32'(ser_last), 32'd0);
        check_eq("mid_rst_level", 32'(ser_level), 32'd0);
        #1;
        rst = 1'b0;
        in_valid = 1'b1; in_data = B2;
        tick();
        in_valid = 1'b0;
        check_eq("mid_restart_w0", ser_data, b2w[0]);
        check_eq("mid_restart_last", 32'(ser_last), 32'd0);
        tick();
        check_eq("mid_restart_w1", ser_data, b2w[1]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes_out_serializer.md
AES_OUT_SERIALIZER -- requirements
Module: aes_out_serializer

Interface
REQ-001 Parameter: DEPTH, default 2, number of 128-bit blocks buffered (legal values 2 or 4).
REQ-002 AES_clk  input  1  single clock; all state updates on rising edge.
REQ-003 AES_rst  input  1  reset, asynchronous assert, active-high.
REQ-004 AES_data_out_valid  input  1  one-cycle pulse from the AES core: ciphertext block present.
REQ-005 AES_data_out  input  128  ciphertext block, sampled only when AES_data_out_valid=1.
REQ-006 ser_data  output  32  current output word.
REQ-007 ser_valid  output  1  ser_data valid.
REQ-008 ser_ready  input  1  downstream accepts the word.
REQ-009 ser_last  output  1  current word is word 3 (last) of a block.
REQ-010 ser_level  output  $clog2(DEPTH)+1  number of blocks buffered.
REQ-011 ser_ovf  output  1  sticky overflow flag.

Function
REQ-012 Capture: on an edge with AES_data_out_valid=1 and (level<DEPTH, or a block pop on the same edge), the block SHALL be written to the FIFO tail.
REQ-013 Capture when level=DEPTH and no pop on the same edge: block dropped, FIFO unchanged, ser_ovf set to 1 and held until reset.
REQ-014 ser_valid SHALL equal (level!=0); first word is valid in the cycle after the capture edge (latency 1 cycle).
REQ-015 Word order: MSB first; word index 0 = bits 127:96, 1 = 95:64, 2 = 63:32, 3 = 31:0 of the head block.
REQ-016 Transfer occurs on an edge with ser_valid=1 and ser_ready=1; the 2-bit word counter then increments, wrapping 3->0.
REQ-017 A transfer at word index 3 SHALL pop the head block; when level>1 the next block's word 0 follows in the next cycle with no bubble.
REQ-018 ser_data, ser_last and word index SHALL stay stable while ser_valid=1 and ser_ready=0.
REQ-019 ser_last = ser_valid AND (word index = 3).
REQ-020 Simultaneous push and pop: level unchanged; pushed block lands behind the remaining entries.
REQ-021 With ser_ready held at 1, one block drains in exactly 4 cycles.

Reset
REQ-022 AES_rst=1 SHALL asynchronously clear FIFO pointers, level, word counter and ser_ovf; ser_valid=0, ser_last=0, ser_data=0.
REQ-023 Reset mid-block discards all buffered data and the partial word position; after reset release the next capture restarts at word 0.
REQ-024 FIFO storage array is not reset.

Configuration
REQ-025 Macro AES_OUT_PARITY_EN defined: extra output ser_parity (1 bit) = XOR of ser_data bits (even parity), registered with the data, 0 in reset.
REQ-026 Macro undefined: ser_parity port and its logic are absent; all other behaviour is identical.

Structure
REQ-027 Shared package aes_out_pkg holds BLOCK_W=128, WORD_W=32, WORDS_PER_BLOCK=4 and the word-index typedef.
REQ-028 Block storage is sub-module aes_out_fifo (DEPTH x 128, push/pop/full/empty/level); serializer counter and flags live in the top.

Verification
REQ-029 Reset, then one pulse with 128'h3925841d_02dc09fb_dc118597_196a0b32, ser_ready=1 -> words 3925841d, 02dc09fb, dc118597, 196a0b32 on 4 consecutive cycles starting 1 cycle after capture; ser_last only on 196a0b32.
REQ-030 Two blocks captured 1 cycle apart, ser_ready=1 -> 8 consecutive words, no bubble, ser_level 1->2->1->0.
REQ-031 ser_ready=0 for 5 cycles at word 1 -> ser_data holds 02dc09fb, then resumes with dc118597.
REQ-032 ser_ready=0, DEPTH+1 captures -> ser_ovf=1, level=DEPTH, last block absent from output; ser_ovf stays 1 until AES_rst.
REQ-033 AES_rst pulse asserted after word 2 is sent -> ser_valid=0 immediately; next capture outputs from word 0.
REQ-034 With AES_OUT_PARITY_EN: word 3925841d -> ser_parity=1 (13 ones); word 00000000 -> ser_parity=0.
